seg_display_out: RTL and testbench



---
 rtl/seg_display_out_pkg.sv | 26 ++
 rtl/seg_display_out_if.sv | 24 ++
 rtl/seg_hex_decoder.sv | 32 +++
 rtl/seg_display_out.sv | 108 ++++++++++
 tb/tb_seg_display_out.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/seg_display_out_pkg.sv
// Shared IO constants for the seven-segment display peripheral: store addresses and
// the active-high a..g segment patterns for hex digits 0-F.
package seg_display_out_pkg;

    localparam logic [31:0] SEG_DATA_ADDR = 32'hFFFF_FC80;
    localparam logic [31:0] SEG_CTRL_ADDR = 32'hFFFF_FC84;

    // Segment patterns, bit order {g,f,e,d,c,b,a}, 1 = segment lit
    localparam logic [6:0] HEX7_0 = 7'h3F;
    localparam logic [6:0] HEX7_1 = 7'h06;
    localparam logic [6:0] HEX7_2 = 7'h5B;
    localparam logic [6:0] HEX7_3 = 7'h4F;
    localparam logic [6:0] HEX7_4 = 7'h66;
    localparam logic [6:0] HEX7_5 = 7'h6D;
    localparam logic [6:0] HEX7_6 = 7'h7D;
    localparam logic [6:0] HEX7_7 = 7'h07;
    localparam logic [6:0] HEX7_8 = 7'h7F;
    localparam logic [6:0] HEX7_9 = 7'h6F;
    localparam logic [6:0] HEX7_A = 7'h77;
    localparam logic [6:0] HEX7_B = 7'h7C;
    localparam logic [6:0] HEX7_C = 7'h39;
    localparam logic [6:0] HEX7_D = 7'h5E;
    localparam logic [6:0] HEX7_E = 7'h79;
    localparam logic [6:0] HEX7_F = 7'h71;

endpackage

// File: rtl/seg_display_out_if.sv
// CPU-side store bus into the display peripheral: one-cycle store strobe with
// address/data, answered by a one-cycle acknowledge.
interface seg_display_out_if;

    logic        io_write;
    logic [31:0] io_addr;
    logic [31:0] io_wdata;
    logic        write_ack;

    modport master (
        output io_write,
        output io_addr,
        output io_wdata,
        input  write_ack
    );

    modport slave (
        input  io_write,
        input  io_addr,
        input  io_wdata,
        output write_ack
    );

endinterface

// File: rtl/seg_hex_decoder.sv
// Combinational nibble to seven-segment decoder, active-high {g,f,e,d,c,b,a}.
module seg_hex_decoder
    import seg_display_out_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = HEX7_0;
        case (nibble)
            4'h0: seg = HEX7_0;
            4'h1: seg = HEX7_1;
            4'h2: seg = HEX7_2;
            4'h3: seg = HEX7_3;
            4'h4: seg = HEX7_4;
            4'h5: seg = HEX7_5;
            4'h6: seg = HEX7_6;
            4'h7: seg = HEX7_7;
            4'h8: seg = HEX7_8;
            4'h9: seg = HEX7_9;
            4'hA: seg = HEX7_A;
            4'hB: seg = HEX7_B;
            4'hC: seg = HEX7_C;
            4'hD: seg = HEX7_D;
            4'hE: seg = HEX7_E;
            4'hF: seg = HEX7_F;
            default: seg = HEX7_0;
        endcase
    end

endmodule

// File: rtl/seg_display_out.sv
// Write-only IO peripheral driving an 8-digit multiplexed common-anode hex display,
// double-buffered per frame. Optional leading-zero blanking: SEG_LEADING_ZERO_BLANK_EN.
module seg_display_out
    import seg_display_out_pkg::*;
#(
    parameter int unsigned SCAN_DIV   = 100000,
    parameter int unsigned NUM_DIGITS = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    seg_display_out_if.slave      bus,
    output logic [NUM_DIGITS-1:0] seg_an,
    output logic [7:0]            seg_cat
);

    localparam int unsigned CNT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DIG_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned DATA_W = 4 * NUM_DIGITS;

    localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [DIG_W-1:0] DIGIT_LAST = DIG_W'(NUM_DIGITS - 1);

    logic [DATA_W-1:0]     data_pend;
    logic [DATA_W-1:0]     data_shadow;
    logic [NUM_DIGITS-1:0] en_mask;
    logic [NUM_DIGITS-1:0] dp_mask;
    logic [CNT_W-1:0]      scan_cnt;
    logic [DIG_W-1:0]      digit_idx;

    logic                  hit_data;
    logic                  hit_ctrl;
    logic                  scan_wrap;
    logic                  frame_start;
    logic [3:0]            nibble;
    logic [6:0]            hex_seg;
    logic                  lz_blank;
    logic [NUM_DIGITS-1:0] an_p0;
    logic [7:0]            cat_p0;

    assign hit_data    = bus.io_write && (bus.io_addr == SEG_DATA_ADDR);
    assign hit_ctrl    = bus.io_write && (bus.io_addr == SEG_CTRL_ADDR);
    assign scan_wrap   = (scan_cnt == SCAN_LAST);
    assign frame_start = scan_wrap && (digit_idx == DIGIT_LAST);

    assign nibble = data_shadow[{digit_idx, 2'b00} +: 4];

    seg_hex_decoder u_hex (
        .nibble (nibble),
        .seg    (hex_seg)
    );

`ifdef SEG_LEADING_ZERO_BLANK_EN
    // Blank when this nibble and everything above it is zero; digit 0 always shows
    assign lz_blank = ((data_shadow >> {digit_idx, 2'b00}) == '0) && (digit_idx != '0);
`else
    assign lz_blank = 1'b0;
`endif

    // Stage p0: combinational digit drive for the digit currently selected
    always_comb begin
        an_p0 = '1;
        if (en_mask[digit_idx] && !lz_blank) begin
            an_p0 = ~(NUM_DIGITS'(1) << digit_idx);
        end
        cat_p0 = ~{dp_mask[digit_idx], hex_seg};
    end

    // Stage p1: write decode, scan/shadow state and registered pin drive
    always_ff @(posedge clock) begin
        if (reset) begin
            data_pend     <= '0;
            data_shadow   <= '0;
            en_mask       <= '1;
            dp_mask       <= '0;
            scan_cnt      <= '0;
            digit_idx     <= '0;
            bus.write_ack <= 1'b0;
            seg_an        <= '1;
            seg_cat       <= 8'hFF;
        end else begin
            bus.write_ack <= hit_data || hit_ctrl;

            if (hit_data) begin
                data_pend <= bus.io_wdata[DATA_W-1:0];
            end
            if (hit_ctrl) begin
                en_mask <= bus.io_wdata[NUM_DIGITS-1:0];
                dp_mask <= bus.io_wdata[8 +: NUM_DIGITS];
            end

            if (scan_wrap) begin
                scan_cnt  <= '0;
                digit_idx <= (digit_idx == DIGIT_LAST) ? '0 : digit_idx + 1'b1;
            end else begin
                scan_cnt  <= scan_cnt + 1'b1;
            end

            // A store landing in the frame-start cycle is picked up one frame later
            if (frame_start) begin
                data_shadow <= data_pend;
            end

            seg_an  <= an_p0;
            seg_cat <= cat_p0;
        end
    end

endmodule

// File: tb/tb_seg_display_out.sv
// Directed bench for seg_display_out: table of per-cycle vectors at SCAN_DIV=4 plus
// hand sequences for frame-edge writes, mid-scan reset and a SCAN_DIV=1 instance.
module tb_seg_display_out;

`ifdef SEG_LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic       clock;
    logic       reset;
    logic [7:0] an0, cat0, an1, cat1;
    int         tests;
    int         fails;
    int         cyc;

    seg_display_out_if bus0 ();
    seg_display_out_if bus1 ();

    seg_display_out #(.SCAN_DIV(4), .NUM_DIGITS(8)) dut (
        .clock   (clock),
        .reset   (reset),
        .bus     (bus0.slave),
        .seg_an  (an0),
        .seg_cat (cat0)
    );

    seg_display_out #(.SCAN_DIV(1), .NUM_DIGITS(8)) dut_fast (
        .clock   (clock),
        .reset   (reset),
        .bus     (bus1.slave),
        .seg_an  (an1),
        .seg_cat (cat1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int          cyc;
        bit          ack;
        bit          chk;
        logic [7:0]  an;
        logic [7:0]  cat;
        bit          lz;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } vec_t;

    vec_t tbl[$];

    localparam logic [31:0] DA = 32'hFFFF_FC80;
    localparam logic [31:0] CA = 32'hFFFF_FC84;
    localparam logic [31:0] BA = 32'hFFFF_FC88;

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
        bus0.io_write = 1'b0;
    endtask

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s at cyc %0d: got %h expected %h", name, cyc, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_an(input logic [7:0] an, input bit lz);
        return (LZB && lz) ? 8'hFF : an;
    endfunction

    task automatic drive(input logic [31:0] addr, input logic [31:0] wdata);
        bus0.io_write = 1'b1;
        bus0.io_addr  = addr;
        bus0.io_wdata = wdata;
    endtask

    task automatic disp(input string name, input logic [7:0] an, input logic [7:0] cat, input bit lz);
        cmp({name, "_an"}, {24'h0, an0}, {24'h0, exp_an(an, lz)});
        cmp({name, "_cat"}, {24'h0, cat0}, {24'h0, cat});
    endtask

    task automatic advance_to(input int target);
        while (cyc < target) tick();
    endtask

    logic [7:0] fast_an [8];

    initial begin
        tests = 0;
        fails = 0;
        cyc   = 0;
        reset = 1'b1;
        bus0.io_write = 1'b0; bus0.io_addr = '0; bus0.io_wdata = '0;
        bus1.io_write = 1'b0; bus1.io_addr = '0; bus1.io_wdata = '0;
        fast_an = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

        //         cyc ack chk an     cat    lz wr addr wdata
        tbl.push_back('{  1, 0, 1, 8'hFE, 8'hC0, 0, 0, DA, 32'h0});
        tbl.push_back('{  4, 0, 1, 8'hFE, 8'hC0, 0, 0, DA, 32'h0});
        tbl.push_back('{  5, 0, 1, 8'hFD, 8'hC0, 1, 0, DA, 32'h0});
        tbl.push_back('{  9, 0, 1, 8'hFB, 8'hC0, 1, 0, DA, 32'h0});
        tbl.push_back('{ 13, 0, 1, 8'hF7, 8'hC0, 1, 0, DA, 32'h0});
        tbl.push_back('{ 17, 0, 1, 8'hEF, 8'hC0, 1, 0, DA, 32'h0});
        tbl.push_back('{ 21, 0, 1, 8'hDF, 8'hC0, 1, 0, DA, 32'h0});
        tbl.push_back('{ 25, 0, 1, 8'hBF, 8'hC0, 1, 0, DA, 32'h0});
        tbl.push_back('{ 29, 0, 1, 8'h7F, 8'hC0, 1, 0, DA, 32'h0});
        tbl.push_back('{ 32, 0, 1, 8'h7F, 8'hC0, 1, 0, DA, 32'h0});
        tbl.push_back('{ 33, 0, 1, 8'hFE, 8'hC0, 0, 0, DA, 32'h0});
        tbl.push_back('{ 37, 0, 1, 8'hFD, 8'hC0, 1, 1, DA, 32'h1234_ABCD});
        tbl.push_back('{ 38, 1, 0, 8'h00, 8'h00, 0, 0, DA, 32'h0});
        tbl.push_back('{ 39, 0, 1, 8'hFD, 8'hC0, 1, 0, DA, 32'h0});
        tbl.push_back('{ 61, 0, 1, 8'h7F, 8'hC0, 1, 0, DA, 32'h0});
        tbl.push_back('{ 64, 0, 1, 8'h7F, 8'hC0, 1, 0, DA, 32'h0});
        tbl.push_back('{ 65, 0, 1, 8'hFE, 8'hA1, 0, 0, DA, 32'h0});
        tbl.push_back('{ 69, 0, 1, 8'hFD, 8'hC6, 0, 0, DA, 32'h0});
        tbl.push_back('{ 73, 0, 1, 8'hFB, 8'h83, 0, 0, DA, 32'h0});
        tbl.push_back('{ 77, 0, 1, 8'hF7, 8'h88, 0, 0, DA, 32'h0});
        tbl.push_back('{ 81, 0, 1, 8'hEF, 8'h99, 0, 0, DA, 32'h0});
        tbl.push_back('{ 85, 0, 1, 8'hDF, 8'hB0, 0, 0, DA, 32'h0});
        tbl.push_back('{ 89, 0, 1, 8'hBF, 8'hA4, 0, 0, DA, 32'h0});
        tbl.push_back('{ 93, 0, 1, 8'h7F, 8'hF9, 0, 1, BA, 32'hDEAD_BEEF});
        tbl.push_back('{ 94, 0, 0, 8'h00, 8'h00, 0, 0, DA, 32'h0});
        tbl.push_back('{ 97, 0, 1, 8'hFE, 8'hA1, 0, 1, CA, 32'h0000_010F});
        tbl.push_back('{ 98, 1, 1, 8'hFE, 8'hA1, 0, 0, DA, 32'h0});
        tbl.push_back('{ 99, 0, 1, 8'hFE, 8'h21, 0, 0, DA, 32'h0});
        tbl.push_back('{101, 0, 1, 8'hFD, 8'hC6, 0, 0, DA, 32'h0});
        tbl.push_back('{113, 0, 1, 8'hFF, 8'h99, 0, 0, DA, 32'h0});
        tbl.push_back('{125, 0, 1, 8'hFF, 8'hF9, 0, 0, DA, 32'h0});
        tbl.push_back('{129, 0, 1, 8'hFE, 8'h21, 0, 0, DA, 32'h0});
        tbl.push_back('{130, 0, 1, 8'hFE, 8'h21, 0, 1, CA, 32'h0000_00FF});
        tbl.push_back('{131, 1, 1, 8'hFE, 8'h21, 0, 1, DA, 32'h8765_4321});
        tbl.push_back('{132, 1, 1, 8'hFE, 8'hA1, 0, 0, DA, 32'h0});
        tbl.push_back('{133, 0, 1, 8'hFD, 8'hC6, 0, 0, DA, 32'h0});
        tbl.push_back('{161, 0, 1, 8'hFE, 8'hF9, 0, 0, DA, 32'h0});
        tbl.push_back('{165, 0, 1, 8'hFD, 8'hA4, 0, 0, DA, 32'h0});
        tbl.push_back('{189, 0, 1, 8'h7F, 8'h80, 0, 0, DA, 32'h0});

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        cmp("rst_an", {24'h0, an0}, 32'hFF);
        cmp("rst_cat", {24'h0, cat0}, 32'hFF);
        cmp("rst_ack", {31'h0, bus0.write_ack}, 32'h0);
        cmp("rst_fast_an", {24'h0, an1}, 32'hFF);
        reset = 1'b0;
        cyc = 0;

        for (int i = 0; i < tbl.size(); i++) begin
            advance_to(tbl[i].cyc);
            cmp($sformatf("ack_v%0d", i), {31'h0, bus0.write_ack}, {31'h0, tbl[i].ack});
            if (tbl[i].chk) disp($sformatf("disp_v%0d", i), tbl[i].an, tbl[i].cat, tbl[i].lz);
            if (tbl[i].wr) drive(tbl[i].addr, tbl[i].wdata);
        end

        // Store landing exactly on the frame-start cycle
        advance_to(191);
        disp("wrap_pre", 8'h7F, 8'h80, 0);
        drive(DA, 32'hCAFE_F00D);
        tick();
        cmp("wrap_ack", {31'h0, bus0.write_ack}, 32'h1);
        tick();
        disp("wrap_old_d0", 8'hFE, 8'hF9, 0);
        advance_to(221);
        disp("wrap_old_d7", 8'h7F, 8'h80, 0);
        advance_to(225);
        disp("wrap_new_d0", 8'hFE, 8'hA1, 0);
        advance_to(229);
        disp("wrap_new_d1", 8'hFD, 8'hC0, 0);

        // Reset in the middle of a digit slot
        tick();
        reset = 1'b1;
        tick();
        cmp("midrst_an", {24'h0, an0}, 32'hFF);
        cmp("midrst_cat", {24'h0, cat0}, 32'hFF);
        cmp("midrst_ack", {31'h0, bus0.write_ack}, 32'h0);
        cmp("midrst_fast_an", {24'h0, an1}, 32'hFF);
        reset = 1'b0;
        cyc = 0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            cmp($sformatf("fast_an_%0d", k), {24'h0, an1},
                {24'h0, exp_an(fast_an[(k - 1) % 8], ((k - 1) % 8) != 0)});
            cmp($sformatf("fast_cat_%0d", k), {24'h0, cat1}, 32'hC0);
            if (k == 1 || k == 4) disp($sformatf("post_rst_%0d", k), 8'hFE, 8'hC0, 0);
            if (k == 5) disp("post_rst_5", 8'hFD, 8'hC0, 1);
        end
        advance_to(33);
        disp("post_rst_f1", 8'hFE, 8'hC0, 0);

        // Small values: leading digits are zero
        drive(DA, 32'h0000_00A5);
        advance_to(65);
        disp("small_d0", 8'hFE, 8'h92, 0);
        advance_to(69);
        disp("small_d1", 8'hFD, 8'h88, 0);
        advance_to(73);
        disp("small_d2", 8'hFB, 8'hC0, 1);
        drive(DA, 32'h0);
        advance_to(97);
        disp("zero_d0", 8'hFE, 8'hC0, 0);
        advance_to(101);
        disp("zero_d1", 8'hFD, 8'hC0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
